uart_rx: RTL and testbench

UART receiver that deserialises the 8N1 line driven by the team's uart_tx, making the pair loop back cleanly. It sits directly downstream of the transmit stage, on the serial pin. It synchronises the asynchronous rx line and samples each bit at mid-bit. Each received byte is presented as an 8-bit word with a one-cycle valid strobe.

---
 rtl/uart_rx.sv | 163 ++++++++++++++++
 tb/tb_uart_rx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, one-cycle data_valid strobe.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
   parameter int unsigned CLK_FREQ  = 100_000_000,
   parameter int unsigned BAUD_RATE = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       busy,
   output logic       frame_err,
   output logic       parity_err
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int unsigned CW           = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF   = CW'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

   state_t        state_q, state_d;
   logic          rx_meta_q, rx_s_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    dout_q, dout_d;
   logic          dv_q, dv_d;
   logic          busy_q, busy_d;
   logic          ferr_q, ferr_d;
   logic          perr_q, perr_d;
   logic          par_q, par_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         dout_q    <= '0;
         dv_q      <= 1'b0;
         busy_q    <= 1'b0;
         ferr_q    <= 1'b0;
         perr_q    <= 1'b0;
         par_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         dout_q    <= dout_d;
         dv_q      <= dv_d;
         busy_q    <= busy_d;
         ferr_q    <= ferr_d;
         perr_q    <= perr_d;
         par_q     <= par_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      par_d     = par_q;
      case (state_q)
         IDLE: begin
            if (!rx_s_q) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               state_d   = rx_s_q ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d     = '0;
               shift_d   = {rx_s_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               par_d   = rx_s_q;
               state_d = STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`endif
         STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = rx_s_q ? IDLE : WAIT_HIGH;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_HIGH: begin
            if (rx_s_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Frame results are registered on the stop-sample edge, so busy falls as data_valid rises.
   always_comb begin
      dout_d = dout_q;
      dv_d   = 1'b0;
      ferr_d = ferr_q;
      perr_d = perr_q;
      busy_d = (state_d != IDLE);
      if (state_q == STOP && cnt_q == CNT_LAST) begin
         if (rx_s_q) begin
            dout_d = shift_q;
            dv_d   = 1'b1;
            ferr_d = 1'b0;
            perr_d = ^{shift_q, par_q};
         end else begin
            ferr_d = 1'b1;
         end
      end
   end

   assign data_out   = dout_q;
   assign data_valid = dv_q;
   assign busy       = busy_q;
   assign frame_err  = ferr_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames at 10 clocks per bit.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int unsigned CLK_FREQ = 100_000_000;
   localparam int unsigned BAUD     = 10_000_000;
   localparam int unsigned CPB      = 10;
   localparam int unsigned HALF     = 4;
`ifdef UART_RX_PARITY_EN
   localparam bit          PAR_EN   = 1'b1;
   localparam int unsigned NBITS    = 10;
`else
   localparam bit          PAR_EN   = 1'b0;
   localparam int unsigned NBITS    = 9;
`endif
   // negedges from driving the start bit low to sampling data_valid high
   localparam int unsigned LATENCY  = 2 + HALF + NBITS * CPB + 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx  = 1'b1;
   logic [7:0] data_out;
   logic       data_valid, busy, frame_err, parity_err;

   uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .data_out   (data_out),
      .data_valid (data_valid),
      .busy       (busy),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   initial forever #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] d;
      logic       perr;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_pulses = 0;
   int   exp_pulses = 0;
   time  t_start = 0;
   time  t_valid = 0;
   logic mon_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_bit(input logic b);
      @(negedge clk);
      rx = b;
      repeat (CPB - 1) @(negedge clk);
   endtask

   // stop_low == 0: good frame, expected result queued; otherwise stop held low that many bits
   task automatic send_frame(input logic [7:0] d, input logic par, input int unsigned stop_low);
      exp_t e;
      if (stop_low == 0) begin
         e.d    = d;
         e.perr = PAR_EN ? ^{d, par} : 1'b0;
         sb.push_back(e);
         exp_pulses++;
      end
      @(negedge clk);
      rx = 1'b0;
      t_start = $time;
      repeat (CPB - 1) @(negedge clk);
      for (int unsigned i = 0; i < 8; i++) drive_bit(d[i]);
      if (PAR_EN) drive_bit(par);
      if (stop_low == 0) drive_bit(1'b1);
      else for (int unsigned i = 0; i < stop_low; i++) drive_bit(1'b0);
   endtask

   // Monitor: pops the scoreboard on every data_valid pulse.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (data_valid) begin
            n_pulses++;
            t_valid = $time;
            check("dv_one_cycle", mon_prev, 1'b0);
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_valid: got data_out 0x%0h with no frame expected", data_out);
            end else begin
               e = sb.pop_front();
               check("data_out", data_out, e.d);
               check("parity_err", parity_err, e.perr);
               check("frame_err_on_valid", frame_err, 1'b0);
            end
         end
         mon_prev = data_valid;
      end
   end

   initial begin
      #200us;
      $display("FAIL timeout: simulation did not finish, %0d checks so far", n_tests);
      $fatal(1, "timeout");
   end

   initial begin
      // reset state
      rst = 1'b0;
      rx  = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_data_out", data_out, 8'h00);
      check("rst_valid", data_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_frame_err", frame_err, 1'b0);
      check("rst_parity_err", parity_err, 1'b0);
      rst = 1'b1;
      repeat (CPB) @(negedge clk);

      // short low glitch rejected in START
      rx = 1'b0;
      repeat (3) @(negedge clk);
      check("glitch_busy_rises", busy, 1'b1);
      rx = 1'b1;
      repeat (2 + HALF + 3 - 3) @(negedge clk);
      check("glitch_busy_clear", busy, 1'b0);
      check("glitch_data_out", data_out, 8'h00);
      check("glitch_frame_err", frame_err, 1'b0);
      repeat (CPB) @(negedge clk);

      // single good frame with latency measurement
      t_valid = 0;
      send_frame(8'hA5, ^8'hA5, 0);
      check("latency", 32'((t_valid - t_start) / 10), LATENCY);
      repeat (CPB) @(negedge clk);
      check("a5_busy_low", busy, 1'b0);
      check("a5_frame_err", frame_err, 1'b0);
      check("a5_hold", data_out, 8'hA5);

      // bad stop bit held low for two bits, then recovery frame
      send_frame(8'h3C, ^8'h3C, 2);
      check("bad_stop_frame_err", frame_err, 1'b1);
      check("bad_stop_wait_high", busy, 1'b1);
      check("bad_stop_data_hold", data_out, 8'hA5);
      drive_bit(1'b1);
      check("wait_high_exit", busy, 1'b0);
      check("frame_err_sticky", frame_err, 1'b1);
      send_frame(8'h55, ^8'h55, 0);
      repeat (CPB) @(negedge clk);
      check("55_clears_frame_err", frame_err, 1'b0);
      check("55_data", data_out, 8'h55);

      // back-to-back frames, no idle gap
      send_frame(8'h00, ^8'h00, 0);
      send_frame(8'hFF, ^8'hFF, 0);
      repeat (CPB) @(negedge clk);
      check("b2b_last", data_out, 8'hFF);
      check("b2b_pulses", n_pulses, exp_pulses);

      // reset in the middle of DATA
      drive_bit(1'b0);
      for (int unsigned i = 0; i < 4; i++) drive_bit(i < 2 ? 1'b1 : 1'b0);
      @(negedge clk);
      rst = 1'b0;
      rx  = 1'b1;
      @(negedge clk);
      check("midrst_data_out", data_out, 8'h00);
      check("midrst_busy", busy, 1'b0);
      check("midrst_valid", data_valid, 1'b0);
      check("midrst_frame_err", frame_err, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      check("midrst_no_pulse", n_pulses, exp_pulses);
      send_frame(8'h81, ^8'h81, 0);
      repeat (CPB) @(negedge clk);
      check("81_data", data_out, 8'h81);

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 0);
      repeat (CPB) @(negedge clk);
      check("par_good", parity_err, 1'b0);
      send_frame(8'h07, 1'b0, 0);
      repeat (CPB) @(negedge clk);
      check("par_bad", parity_err, 1'b1);
      check("par_bad_data", data_out, 8'h07);
      check("par_bad_held_busy", busy, 1'b0);
`endif

      repeat (20) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      check("total_pulses", n_pulses, exp_pulses);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
